// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM state
// encoding, the external-interrupt cause value and standard exception causes.
package trap_ctrl_pkg;

    // Trap sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_JUMP = 2'd2,
        ST_RET  = 2'd3
    } trap_state_e;

    // mcause value for a machine external interrupt (interrupt bit set, code 11)
    localparam logic [31:0] IRQ_CAUSE_M_EXT        = 32'h8000_000B;

    // Standard synchronous exception cause codes
    localparam logic [31:0] CAUSE_INSTR_MISALIGNED = 32'd0;
    localparam logic [31:0] CAUSE_INSTR_FAULT      = 32'd1;
    localparam logic [31:0] CAUSE_ILLEGAL_INSTR    = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT       = 32'd3;
    localparam logic [31:0] CAUSE_LOAD_MISALIGNED  = 32'd4;
    localparam logic [31:0] CAUSE_LOAD_FAULT       = 32'd5;
    localparam logic [31:0] CAUSE_STORE_MISALIGNED = 32'd6;
    localparam logic [31:0] CAUSE_STORE_FAULT      = 32'd7;
    localparam logic [31:0] CAUSE_ECALL_U          = 32'd8;
    localparam logic [31:0] CAUSE_ECALL_M          = 32'd11;

endpackage : trap_ctrl_pkg

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer between WB and the CSR file. Accepts one
// exception, mret or external interrupt while idle, writes mcause/mtval/mepc,
// flushes the pipeline and redirects fetch to mtvec (trap) or mepc (mret).
// Outputs are decoded only from the registered state and latches, so no WB
// input reaches an output combinationally.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned         XLEN      = 32,
    parameter logic [XLEN-1:0]     IRQ_CAUSE = XLEN'(IRQ_CAUSE_M_EXT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid_i,
    input  logic [XLEN-1:0] wb_pc_i,
    input  logic            wb_excp_valid_i,
    input  logic [XLEN-1:0] wb_excp_cause_i,
    input  logic [XLEN-1:0] wb_excp_tval_i,
    input  logic            wb_mret_i,
    input  logic            ext_irq_i,
    input  logic [XLEN-1:0] mtvec_rdata_i,
    input  logic [XLEN-1:0] mepc_rdata_i,
    output logic            mcause_wen_o,
    output logic [XLEN-1:0] mcause_wdata_o,
    output logic            mtval_wen_o,
    output logic [XLEN-1:0] mtval_wdata_o,
    output logic            mepc_wen_o,
    output logic [XLEN-1:0] mepc_wdata_o,
    output logic            flush_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            trap_busy_o,
    output logic            mie_o
);

    trap_state_e     state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] tval_q,  tval_d;
    logic [XLEN-1:0] epc_q,   epc_d;
    logic            mie_q,   mie_d;

    // State, trap latches and interrupt-enable registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cause_q <= '0;
            tval_q  <= '0;
            epc_q   <= '0;
            mie_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            epc_q   <= epc_d;
            mie_q   <= mie_d;
        end
    end

    // Next-state logic: event priority in IDLE, fixed sequence otherwise
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        tval_d  = tval_q;
        epc_d   = epc_q;
        mie_d   = mie_q;
        case (state_q)
            ST_IDLE: begin
                if (wb_excp_valid_i) begin
                    // Faulting instruction does not complete; epc points at it
                    cause_d = wb_excp_cause_i;
                    tval_d  = wb_excp_tval_i;
                    epc_d   = wb_pc_i;
                    state_d = ST_SAVE;
                end else if (wb_mret_i && wb_valid_i) begin
                    state_d = ST_RET;
                end else if (ext_irq_i && mie_q && wb_valid_i) begin
                    // WB instruction retires, so resume after it (wraps at 2^XLEN)
                    cause_d = IRQ_CAUSE;
                    tval_d  = '0;
                    epc_d   = wb_pc_i + XLEN'(32'd4);
                    state_d = ST_SAVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAVE: begin
                mie_d   = 1'b0;
                state_d = ST_JUMP;
            end
            ST_JUMP: begin
                state_d = ST_IDLE;
            end
            ST_RET: begin
                mie_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state; data buses are zero when unused
    always_comb begin
        mcause_wen_o     = 1'b0;
        mcause_wdata_o   = '0;
        mtval_wen_o      = 1'b0;
        mtval_wdata_o    = '0;
        mepc_wen_o       = 1'b0;
        mepc_wdata_o     = '0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        trap_busy_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                trap_busy_o = 1'b0;
            end
            ST_SAVE: begin
                mcause_wen_o   = 1'b1;
                mcause_wdata_o = cause_q;
                mtval_wen_o    = 1'b1;
                mtval_wdata_o  = tval_q;
                mepc_wen_o     = 1'b1;
                mepc_wdata_o   = epc_q;
                flush_o        = 1'b1;
                trap_busy_o    = 1'b1;
            end
            ST_JUMP: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = mtvec_rdata_i;
                trap_busy_o      = 1'b1;
            end
            ST_RET: begin
                flush_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = mepc_rdata_i;
                trap_busy_o      = 1'b1;
            end
            default: begin
                trap_busy_o = 1'b0;
            end
        endcase
    end

    assign mie_o = mie_q;

endmodule : trap_ctrl

// File: tb/tb_trap_ctrl.sv
// Testbench for trap_ctrl: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid_i;
    logic [31:0] wb_pc_i;
    logic        wb_excp_valid_i;
    logic [31:0] wb_excp_cause_i;
    logic [31:0] wb_excp_tval_i;
    logic        wb_mret_i;
    logic        ext_irq_i;
    logic [31:0] mtvec_rdata_i;
    logic [31:0] mepc_rdata_i;
    logic        mcause_wen_o;
    logic [31:0] mcause_wdata_o;
    logic        mtval_wen_o;
    logic [31:0] mtval_wdata_o;
    logic        mepc_wen_o;
    logic [31:0] mepc_wdata_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        trap_busy_o;
    logic        mie_o;

    trap_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .wb_valid_i       (wb_valid_i),
        .wb_pc_i          (wb_pc_i),
        .wb_excp_valid_i  (wb_excp_valid_i),
        .wb_excp_cause_i  (wb_excp_cause_i),
        .wb_excp_tval_i   (wb_excp_tval_i),
        .wb_mret_i        (wb_mret_i),
        .ext_irq_i        (ext_irq_i),
        .mtvec_rdata_i    (mtvec_rdata_i),
        .mepc_rdata_i     (mepc_rdata_i),
        .mcause_wen_o     (mcause_wen_o),
        .mcause_wdata_o   (mcause_wdata_o),
        .mtval_wen_o      (mtval_wen_o),
        .mtval_wdata_o    (mtval_wdata_o),
        .mepc_wen_o       (mepc_wen_o),
        .mepc_wdata_o     (mepc_wdata_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .trap_busy_o      (trap_busy_o),
        .mie_o            (mie_o)
    );

    always #5 clk = ~clk;

    // One expected output cycle of the model. src: 0 none, 1 mtvec, 2 mepc.
    // mie_act: 0 keep, 1 clear at end of cycle, 2 set at end of cycle.
    typedef struct {
        logic        wen;
        logic [31:0] mc;
        logic [31:0] mt;
        logic [31:0] me;
        logic        flush;
        logic        rv;
        int          src;
        logic        busy;
        int          mie_act;
    } rec_t;

    rec_t cur;
    rec_t plan[$];
    logic m_mie;
    logic after_rst;
    int   total;
    int   bad;

    function automatic rec_t idle_rec();
        rec_t r;
        r.wen = 1'b0; r.mc = 32'd0; r.mt = 32'd0; r.me = 32'd0;
        r.flush = 1'b0; r.rv = 1'b0; r.src = 0; r.busy = 1'b0; r.mie_act = 0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A trap is two cycles: CSR write + flush, then redirect to mtvec
    task automatic plan_trap(input logic [31:0] c, input logic [31:0] t, input logic [31:0] e);
        rec_t s;
        rec_t j;
        s = idle_rec();
        s.wen = 1'b1; s.mc = c; s.mt = t; s.me = e;
        s.flush = 1'b1; s.busy = 1'b1; s.mie_act = 1;
        j = idle_rec();
        j.rv = 1'b1; j.src = 1; j.busy = 1'b1;
        plan.push_back(s);
        plan.push_back(j);
    endtask

    // Advance one clock: predict, clock the DUT, compare every output
    task automatic tick();
        rec_t        nxt;
        logic [31:0] exp_rpc;
        nxt = idle_rec();
        if (rst) begin
            plan.delete();
            m_mie     = 1'b1;
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (!cur.busy) begin
                if (wb_excp_valid_i)
                    plan_trap(wb_excp_cause_i, wb_excp_tval_i, wb_pc_i);
                else if (wb_mret_i && wb_valid_i) begin
                    rec_t r;
                    r = idle_rec();
                    r.flush = 1'b1; r.rv = 1'b1; r.src = 2; r.busy = 1'b1; r.mie_act = 2;
                    plan.push_back(r);
                end else if (ext_irq_i && m_mie && wb_valid_i)
                    plan_trap(32'h8000_000B, 32'd0, wb_pc_i + 32'd4);
            end
            if (cur.mie_act == 1) m_mie = 1'b0;
            if (cur.mie_act == 2) m_mie = 1'b1;
            if (plan.size() > 0) nxt = plan.pop_front();
        end
        @(posedge clk);
        #1;
        cur = nxt;
        chk("mcause_wen", {31'd0, mcause_wen_o}, {31'd0, cur.wen});
        chk("mtval_wen",  {31'd0, mtval_wen_o},  {31'd0, cur.wen});
        chk("mepc_wen",   {31'd0, mepc_wen_o},   {31'd0, cur.wen});
        chk("flush",      {31'd0, flush_o},      {31'd0, cur.flush});
        chk("redir_vld",  {31'd0, redirect_valid_o}, {31'd0, cur.rv});
        chk("busy",       {31'd0, trap_busy_o},  {31'd0, cur.busy});
        chk("mie",        {31'd0, mie_o},        {31'd0, m_mie});
        if (cur.wen || after_rst) begin
            chk("mcause_wdata", mcause_wdata_o, cur.mc);
            chk("mtval_wdata",  mtval_wdata_o,  cur.mt);
            chk("mepc_wdata",   mepc_wdata_o,   cur.me);
        end
        if (cur.rv || after_rst) begin
            exp_rpc = (cur.src == 1) ? mtvec_rdata_i : (cur.src == 2) ? mepc_rdata_i : 32'd0;
            chk("redir_pc", redirect_pc_o, exp_rpc);
        end
    endtask

    task automatic quiet();
        wb_valid_i = 1'b0; wb_excp_valid_i = 1'b0; wb_mret_i = 1'b0; ext_irq_i = 1'b0;
        wb_excp_cause_i = 32'd0; wb_excp_tval_i = 32'd0;
    endtask

    initial begin
        total = 0; bad = 0;
        cur = idle_rec();
        m_mie = 1'b1; after_rst = 1'b0;
        rst = 1'b1; quiet(); wb_pc_i = 32'd0;
        mtvec_rdata_i = 32'd40; mepc_rdata_i = 32'd0;

        // Reset
        tick(); tick(); tick();
        chk("rst_mie", {31'd0, mie_o}, 32'd1);
        chk("rst_busy", {31'd0, trap_busy_o}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: illegal-instruction trap
        wb_excp_valid_i = 1'b1; wb_excp_cause_i = 32'd2; wb_excp_tval_i = 32'h0000_FFFF;
        wb_pc_i = 32'h100;
        tick();
        chk("t1_mcause", mcause_wdata_o, 32'd2);
        chk("t1_mtval", mtval_wdata_o, 32'h0000_FFFF);
        chk("t1_mepc", mepc_wdata_o, 32'h100);
        chk("t1_flush", {31'd0, flush_o}, 32'd1);
        quiet();
        tick();
        chk("t1_redir", redirect_pc_o, 32'd40);
        tick();
        chk("t1_mie", {31'd0, mie_o}, 32'd0);

        // 2: mret
        wb_mret_i = 1'b1; wb_valid_i = 1'b1; mepc_rdata_i = 32'h104;
        tick();
        chk("t2_redir", redirect_pc_o, 32'h104);
        chk("t2_wen", {31'd0, mcause_wen_o}, 32'd0);
        quiet();
        tick();
        chk("t2_mie", {31'd0, mie_o}, 32'd1);

        // 3: external interrupt, level held afterwards while mie=0
        ext_irq_i = 1'b1; wb_valid_i = 1'b1; wb_pc_i = 32'h200;
        tick();
        chk("t3_mcause", mcause_wdata_o, 32'h8000_000B);
        chk("t3_mtval", mtval_wdata_o, 32'd0);
        chk("t3_mepc", mepc_wdata_o, 32'h204);
        tick();
        chk("t3_redir", redirect_pc_o, 32'd40);
        tick();
        tick();
        chk("t3_no_retake", {31'd0, trap_busy_o}, 32'd0);
        quiet();
        wb_mret_i = 1'b1; wb_valid_i = 1'b1;
        tick();
        quiet();
        tick();

        // 4: exception + mret + interrupt together
        wb_excp_valid_i = 1'b1; wb_excp_cause_i = 32'd11; wb_pc_i = 32'h300;
        wb_mret_i = 1'b1; wb_valid_i = 1'b1; ext_irq_i = 1'b1;
        tick();
        chk("t4_mcause", mcause_wdata_o, 32'd11);
        chk("t4_mepc", mepc_wdata_o, 32'h300);
        wb_excp_valid_i = 1'b0; wb_mret_i = 1'b0; wb_valid_i = 1'b0;
        tick(); tick();
        chk("t4_idle", {31'd0, trap_busy_o}, 32'd0);
        wb_mret_i = 1'b1; wb_valid_i = 1'b1;
        tick();
        wb_mret_i = 1'b0; wb_pc_i = 32'h400;
        tick();
        tick();
        chk("t4_irq_cause", mcause_wdata_o, 32'h8000_000B);
        chk("t4_irq_epc", mepc_wdata_o, 32'h404);
        quiet();
        tick(); tick();

        // 5: exception during JUMP is ignored; reset during SAVE
        wb_excp_valid_i = 1'b1; wb_excp_cause_i = 32'd4; wb_pc_i = 32'h500;
        tick();
        wb_excp_valid_i = 1'b0;
        tick();
        wb_excp_valid_i = 1'b1; wb_excp_cause_i = 32'd5;
        tick();
        chk("t5_no_save", {31'd0, mcause_wen_o}, 32'd0);
        quiet();
        tick();
        wb_excp_valid_i = 1'b1; wb_excp_cause_i = 32'd2; wb_pc_i = 32'h600;
        tick();
        quiet();
        rst = 1'b1;
        tick();
        chk("t5_rst_wen", {31'd0, mepc_wen_o}, 32'd0);
        chk("t5_rst_mie", {31'd0, mie_o}, 32'd1);
        rst = 1'b0;
        tick();
        chk("t5_no_redir", {31'd0, redirect_valid_o}, 32'd0);

        // 6: epc wrap on interrupt
        ext_irq_i = 1'b1; wb_valid_i = 1'b1; wb_pc_i = 32'hFFFF_FFFC;
        tick();
        chk("t6_wrap", mepc_wdata_o, 32'd0);
        quiet();
        tick(); tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(0, 63) == 0);
            wb_valid_i      = $urandom_range(0, 1);
            wb_excp_valid_i = ($urandom_range(0, 7) == 0);
            wb_mret_i       = ($urandom_range(0, 5) == 0);
            ext_irq_i       = ($urandom_range(0, 2) == 0);
            wb_pc_i         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            wb_excp_cause_i = $urandom_range(0, 15);
            wb_excp_tval_i  = $urandom();
            mtvec_rdata_i   = $urandom();
            mepc_rdata_i    = $urandom();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_trap_ctrl
